// File: rtl/mod_symbol_sched.sv
// mod_symbol_sched
// ----------------
// Symbol scheduler for a simple ASK/FSK/PSK modulator. Accepts one data bit
// per symbol over a valid/ready handshake. It encodes the bit, together with
// the mode latched at that handshake, into a 10-bit control word for the
// downstream datapath register. Each word is held for exactly SYM_CYCLES
// clocks. If no bit is offered when a symbol ends, the block drives a zero
// word and drops back to idle. It also flags an underrun when that happens
// while enabled.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; wins over everything
//   enable      permits acceptance of new bits
//   mode[1:0]   00 ASK, 01 FSK, 10 PSK, 11 reserved (encodes to 0)
//   bit_valid   bit_data is offered
//   bit_data    data bit to modulate
//   bit_ready   block accepts a bit this cycle (combinational)
//   ctrl_word   registered control word, changes only with ctrl_load
//   ctrl_load   registered one-cycle strobe marking a new ctrl_word
//   sym_active  registered, high while a symbol is in progress
//   underrun    registered one-cycle pulse: symbol ended with no bit ready
//
// SYM_CYCLES must lie in 2..65535; the hold counter is reloaded with
// SYM_CYCLES-2 and would wrap for smaller values.

module mod_symbol_sched #(
  parameter int unsigned SYM_CYCLES = 100,
  parameter logic [9:0]  FREQ0      = 10'd32,
  parameter logic [9:0]  FREQ1      = 10'd64,
  parameter logic [9:0]  PHASE_PI   = 10'd512,
  parameter logic [9:0]  AMP_ON     = 10'd1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       bit_ready,
  output logic [9:0] ctrl_word,
  output logic       ctrl_load,
  output logic       sym_active,
  output logic       underrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] MODE_ASK = 2'b00;
  localparam logic [1:0] MODE_FSK = 2'b01;
  localparam logic [1:0] MODE_PSK = 2'b10;

  // LOAD is the first cycle of a symbol and the final HOLD cycle (cnt==0) is
  // the last. The remaining SYM_CYCLES-2 cycles are counted down in HOLD.
  localparam logic [15:0] CNT_RELOAD = 16'(SYM_CYCLES - 2);

  logic [1:0]  state_q,      state_d;
  logic [15:0] cnt_q,        cnt_d;
  logic        bit_q,        bit_d;
  logic [1:0]  mode_q,       mode_d;
  logic [9:0]  ctrl_word_q,  ctrl_word_d;
  logic        ctrl_load_q,  ctrl_load_d;
  logic        sym_active_q, sym_active_d;
  logic        underrun_q,   underrun_d;

  logic        sym_end;
  logic        handshake;

  function automatic logic [9:0] encode(input logic b, input logic [1:0] m);
    logic [9:0] w;
    w = 10'd0;
    case (m)
      MODE_ASK: w = b ? AMP_ON   : 10'd0;
      MODE_FSK: w = b ? FREQ1    : FREQ0;
      MODE_PSK: w = b ? PHASE_PI : 10'd0;
      default:  w = 10'd0;
    endcase
    return w;
  endfunction

  // Last cycle of a symbol: the only point besides IDLE where a new bit can
  // be taken, which keeps back-to-back symbols exactly SYM_CYCLES apart.
  assign sym_end   = (state_q == ST_HOLD) && (cnt_q == 16'd0);
  assign bit_ready = !reset && enable && ((state_q == ST_IDLE) || sym_end);
  assign handshake = bit_valid && bit_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    mode_d       = mode_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_load_d  = 1'b0;
    sym_active_d = sym_active_q;
    underrun_d   = 1'b0;

    if (handshake) begin
      // The word is encoded from the incoming bit/mode at the handshake edge
      // so that it is already on ctrl_word during the LOAD cycle, one cycle
      // after the handshake. The latched copies then govern the rest of the
      // symbol, which is what makes mid-symbol mode changes invisible.
      state_d      = ST_LOAD;
      bit_d        = bit_data;
      mode_d       = mode;
      ctrl_word_d  = encode(bit_data, mode);
      ctrl_load_d  = 1'b1;
      sym_active_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sym_active_d = 1'b0;
        end
        ST_LOAD: begin
          state_d      = ST_HOLD;
          cnt_d        = CNT_RELOAD;
          ctrl_word_d  = encode(bit_q, mode_q);
          sym_active_d = 1'b1;
        end
        ST_HOLD: begin
          if (cnt_q != 16'd0) begin
            cnt_d        = cnt_q - 16'd1;
            ctrl_word_d  = encode(bit_q, mode_q);
            sym_active_d = 1'b1;
          end else begin
            // Symbol over with nothing to follow: blank the output. It is
            // an underrun only if we were willing to take a bit.
            state_d      = ST_IDLE;
            ctrl_word_d  = 10'd0;
            ctrl_load_d  = 1'b1;
            sym_active_d = 1'b0;
            underrun_d   = enable;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          sym_active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      bit_q        <= 1'b0;
      mode_q       <= 2'b00;
      ctrl_word_q  <= 10'd0;
      ctrl_load_q  <= 1'b0;
      sym_active_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      mode_q       <= mode_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_load_q  <= ctrl_load_d;
      sym_active_q <= sym_active_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ctrl_word  = ctrl_word_q;
  assign ctrl_load  = ctrl_load_q;
  assign sym_active = sym_active_q;
  assign underrun   = underrun_q;

endmodule
